// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and sizing helpers for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_e;

    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple chain of full_adder cells
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0]  = ci;
    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
        );
    end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder processing DIGIT bits per clock with valid/ready handshakes
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o,
    output logic             ovf_o
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cnt_width(NDIG);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    sadd_state_e            state;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       a_sr, b_sr;
    logic                   carry_q;
    logic [DIGIT-1:0]       d_sum;
    logic                   d_co, d_cmsb;
    logic [WIDTH+DIGIT-1:0] sum_shift;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sr[DIGIT-1:0]),
        .b    (b_sr[DIGIT-1:0]),
        .ci   (carry_q),
        .s    (d_sum),
        .co   (d_co),
        .c_msb(d_cmsb)
    );

    // new digit enters the sum register from the top; works unchanged when NDIG==1
    assign sum_shift = {d_sum, sum_o} >> DIGIT;
    assign ready_o   = (state == IDLE);
    assign valid_o   = (state == DONE);

    // handshake FSM, digit counter, operand shifters and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            a_sr    <= '0;
            b_sr    <= '0;
            carry_q <= 1'b0;
            sum_o   <= '0;
            c_o     <= 1'b0;
            ovf_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (valid_i) begin
                    a_sr    <= a_i;
                    b_sr    <= b_i;
                    carry_q <= c_i;
                    cnt     <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    sum_o   <= sum_shift[WIDTH-1:0];
                    a_sr    <= a_sr >> DIGIT;
                    b_sr    <= b_sr >> DIGIT;
                    carry_q <= d_co;
                    if (cnt == CW'(NDIG - 1)) begin
                        c_o   <= d_co;
                        ovf_o <= d_co ^ d_cmsb;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: if (ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (8/4 and 8/8 configurations)
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       ci = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, r0 = 1'b0, r1 = 1'b0;
    logic       rdy0, rdy1, vo0, vo1, co0, co1, ovf0, ovf1;
    logic [7:0] sum0, sum1;
    int         passed = 0, total = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(rdy0),
        .a_i(a), .b_i(b), .c_i(ci), .valid_o(vo0), .ready_i(r0),
        .sum_o(sum0), .c_o(co0), .ovf_o(ovf0)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1),
        .a_i(a), .b_i(b), .c_i(ci), .valid_o(vo1), .ready_i(r1),
        .sum_o(sum1), .c_o(co1), .ovf_o(ovf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic start(input bit s, input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        @(negedge clk);
        a = ta; b = tb; ci = tc;
        if (s) v1 = 1'b1; else v0 = 1'b1;
        @(posedge clk);
        #1 v0 = 1'b0; v1 = 1'b0;
    endtask

    task automatic wait_done(input bit s, input int lat, input string tag);
        int n = 0;
        while (n < 20 && !(s ? vo1 : vo0)) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, "_lat"}, n, lat);
    endtask

    task automatic chk_res(input bit s, input string tag, input logic [7:0] es, input logic ec, input logic eo);
        chk({tag, "_sum"}, s ? sum1 : sum0, es);
        chk({tag, "_c"},   s ? co1 : co0, ec);
        chk({tag, "_ovf"}, s ? ovf1 : ovf0, eo);
    endtask

    task automatic release_res(input bit s, input string tag);
        @(negedge clk);
        if (s) r1 = 1'b1; else r0 = 1'b1;
        @(posedge clk);
        #1 r0 = 1'b0; r1 = 1'b0;
        chk({tag, "_vo_drop"}, s ? vo1 : vo0, 0);
        chk({tag, "_rdy_back"}, s ? rdy1 : rdy0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", rdy0, 1);
        chk("rst_vo", vo0, 0);
        chk("rst_sum", sum0, 8'h00);
        chk("rst_c", co0, 0);
        chk("rst_ovf", ovf0, 0);
        rst_n = 1'b1;

        start(0, 8'hFF, 8'h01, 0);
        wait_done(0, 2, "ff01");
        chk_res(0, "ff01", 8'h00, 1, 0);
        release_res(0, "ff01");

        start(0, 8'h7F, 8'h01, 0);
        wait_done(0, 2, "7f01");
        chk_res(0, "7f01", 8'h80, 0, 1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rdy", rdy0, 1);
        chk("async_vo", vo0, 0);
        chk("async_sum", sum0, 8'h00);
        chk("async_ovf", ovf0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        start(0, 8'h80, 8'h80, 0);
        wait_done(0, 2, "8080");
        chk_res(0, "8080", 8'h00, 1, 1);
        release_res(0, "8080");

        start(0, 8'hFF, 8'hFF, 1);
        wait_done(0, 2, "ffff1");
        chk_res(0, "ffff1", 8'hFF, 1, 0);
        release_res(0, "ffff1");

        start(1, 8'hFF, 8'hFF, 1);
        wait_done(1, 1, "w8_ffff1");
        chk_res(1, "w8_ffff1", 8'hFF, 1, 0);
        release_res(1, "w8_ffff1");

        start(0, 8'h55, 8'h22, 0);
        a = 8'hAA; b = 8'hAA; ci = 1'b1; v0 = 1'b1;
        chk("bp_run_rdy", rdy0, 0);
        wait_done(0, 2, "bp");
        for (int i = 0; i < 5; i++) begin
            chk_res(0, "bp_hold", 8'h77, 0, 0);
            chk("bp_vo", vo0, 1);
            chk("bp_rdy", rdy0, 0);
            @(posedge clk);
            #1 v0 = ~v0;
        end
        v0 = 1'b0;
        release_res(0, "bp");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("bp_no_second", vo0, 0);
        end

        start(0, 8'hC3, 8'h3C, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midrun_rdy", rdy0, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("midrun_no_vo", vo0, 0);
        end

        start(0, 8'h12, 8'h34, 0);
        wait_done(0, 2, "1234");
        chk_res(0, "1234", 8'h46, 0, 0);
        release_res(0, "1234");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised multi-cycle adder; successor to the single-bit full_adder cell.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered inter-digit carry.
- Valid/ready handshake on input and output; sits between operand producers and datapath consumers where area matters more than throughput.
- Reports carry-out and two's-complement overflow.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- DIGIT, 4, bits added per cycle. WIDTH % DIGIT == 0 is required, and an elaboration-time assertion checks it.
- NDIG, WIDTH/DIGIT (localparam), number of digit cycles per operation.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  block can accept operands.
- a_i  in  WIDTH  operand A.
- b_i  in  WIDTH  operand B.
- c_i  in  1  carry-in.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- sum_o  out  WIDTH  sum (A+B+c_i) mod 2^WIDTH.
- c_o  out  1  carry-out of the MSB.
- ovf_o  out  1  signed overflow (carry into MSB XOR carry out of MSB).

Interface decision: one clock (clk_i). Reset rst_ni is asynchronous and active-low.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst_ni=0, asynchronous):
  - State goes to IDLE and the digit counter clears to 0.
  - Operand shift registers, carry register, sum_o, c_o and ovf_o clear to 0.
  - Outputs during reset: valid_o=0, ready_o=1.
- ready_o = (state==IDLE). valid_o = (state==DONE). Both are decoded from registered state only.
- IDLE:
  - On valid_i && ready_o at an edge, latch a_i and b_i into shift registers A_sr and B_sr, set carry_q=c_i, set cnt=0, and go to RUN.
  - valid_i while not in IDLE is ignored. Operands are not re-sampled.
- RUN, each edge:
  - Add A_sr[DIGIT-1:0] + B_sr[DIGIT-1:0] + carry_q.
  - Shift the digit sum into the sum register from the top (right shift by DIGIT).
  - Right-shift A_sr and B_sr by DIGIT.
  - carry_q takes the digit carry-out. cnt increments.
  - On the edge where cnt==NDIG-1:
    - c_o takes the digit carry-out.
    - ovf_o takes (carry into bit DIGIT-1 of that digit) XOR (digit carry-out).
    - Go to DONE.
- Latency: valid_o rises exactly NDIG cycles after the accept edge. With NDIG=1 (DIGIT==WIDTH), DONE follows the accept by one cycle.
- DONE:
  - sum_o, c_o and ovf_o are held stable while valid_o=1 and ready_i=0, for any backpressure duration.
  - On ready_i high at an edge, go to IDLE. Outputs keep their last values; valid_o drops.
  - No accept in the same cycle as the output handshake. Throughput is one operation per NDIG+2 cycles minimum.
- Arithmetic:
  - Unsigned modulo 2^WIDTH. Digit adder is DIGIT+1 bits wide internally.
  - No sign extension. c_i participates only in digit 0.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No partial result is ever presented with valid_o=1.
- cnt width: $clog2(NDIG) bits, minimum 1. cnt never wraps within an operation.

Decomposition:
- Package serial_adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sadd_state_e.
  - A function computing the cnt width from NDIG.
- Sub-module digit_adder (parameter DIGIT) is a combinational ripple chain of existing full_adder cells. Ports: a, b, carry-in, sum, carry-out, and carry into the top bit (used for ovf_o).
- FSM, counter and shift registers live in serial_adder.

Test Plan (WIDTH=8, DIGIT=4, so NDIG=2, unless noted):
- Reset: hold rst_ni=0 for 3 cycles, including asynchronous assertion mid-cycle → ready_o=1, valid_o=0, sum_o=0x00, c_o=0, ovf_o=0 with no clock edge needed.
- a=0xFF, b=0x01, c_i=0 → valid_o rises 2 cycles after accept; sum_o=0x00, c_o=1, ovf_o=0.
- a=0x7F, b=0x01, c_i=0 → sum_o=0x80, c_o=0, ovf_o=1. Then a=0x80, b=0x80 → sum_o=0x00, c_o=1, ovf_o=1.
- a=0xFF, b=0xFF, c_i=1 → sum_o=0xFF, c_o=1, ovf_o=0. Repeat with WIDTH=DIGIT=8 → same result, latency 1 cycle.
- Backpressure: ready_i=0 for 5 cycles in DONE, valid_i pulsed with new operands during RUN and DONE → outputs unchanged, ready_o=0 throughout, no second result produced.
- Reset asserted in the cycle after accept (mid-RUN) → IDLE, valid_o never asserts. Next op a=0x12, b=0x34, c_i=0 → sum_o=0x46, c_o=0, ovf_o=0.
